// File: rtl/alu_sequencer.sv
// Instruction sequencer for an external combinational ALU. It accepts register-register
// instructions, reads operands from an 8x16 register file, and writes the ALU result back.
module alu_sequencer #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [DATA_W-1:0]        alu_in1,
    output logic [DATA_W-1:0]        alu_in2,
    output logic [2:0]               alu_mode,
    input  logic [DATA_W-1:0]        alu_result,
    output logic [DATA_W-1:0]        result,
    output logic                     done,
    output logic [15:0]              op_count
);

    // state | meaning
    // IDLE  | ready for an instruction; fields latched on accept
    // READ  | operands and mode registered onto the ALU interface
    // EXEC  | ALU output captured into result
    // WB    | result written to rd (unless r0), done pulsed, op_count bumped
    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam int AW = $clog2(NREGS);

    state_t            state, state_nxt;
    logic [2:0]        mode_q;
    logic [AW-1:0]     rd_q, rs1_q, rs2_q;
    logic [DATA_W-1:0] rf [NREGS];
    logic              accept, do_read, do_exec, do_wb;
    logic [3:0]        unused_instr_bits;

    assign unused_instr_bits = instr[3:0];

    // r0 is architecturally zero regardless of what the array holds
    function automatic logic [DATA_W-1:0] rf_read(input logic [AW-1:0] addr);
        return (addr == '0) ? '0 : rf[addr];
    endfunction

    assign dbg_data = rf_read(dbg_addr);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        do_read     = 1'b0;
        do_exec     = 1'b0;
        do_wb       = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                do_read   = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                do_exec   = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                do_wb     = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_mode <= '0;
            result   <= '0;
            op_count <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            if (accept) begin
                mode_q <= instr[15:13];
                rd_q   <= instr[12:10];
                rs1_q  <= instr[9:7];
                rs2_q  <= instr[6:4];
            end
            if (do_read) begin
                alu_in1  <= rf_read(rs1_q);
                alu_in2  <= rf_read(rs2_q);
                alu_mode <= mode_q;
            end
            if (do_exec) result <= alu_result;
            // loader write first so a same-register write-back overrides it
            if (ld_en && ld_addr != '0) rf[ld_addr] <= ld_data;
            if (do_wb) begin
                if (rd_q != '0) rf[rd_q] <= result;
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: supplies the external ALU, tracks a transaction-level
// reference of register file and outputs, and checks the DUT every cycle.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] alu_in1, alu_in2, alu_result, result, op_count;
    logic [2:0]  alu_mode;
    logic        done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .result     (result),
        .done       (done),
        .op_count   (op_count)
    );

    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] m);
        case (m)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a >> b[3:0];
            3'd3:    return a << b[3:0];
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return ~a;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_in1, alu_in2, alu_mode);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase = cycles since acceptance (-1 when idle). An instruction
    // reads operands one edge after acceptance, captures the ALU output at the
    // next, and retires (write-back, count) at the one after that.
    int          phase = -1;
    bit          live  = 1'b0;
    int          cyc   = 0;
    logic [15:0] m_rf [8];
    logic [15:0] e_in1, e_in2, e_result, e_count;
    logic [2:0]  e_mode;
    logic [15:0] pend;
    bit          retire_now;
    int          done_cyc[$];

    always @(posedge clk) begin
        cyc++;
        retire_now = 1'b0;
        if (rst) begin
            live   = 1'b1;
            phase  = -1;
            e_in1  = '0; e_in2 = '0; e_mode = '0; e_result = '0; e_count = '0;
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
        end else begin
            if (phase == -1) begin
                if (instr_valid) begin
                    pend  = instr;
                    phase = 0;
                end
            end else if (phase == 0) begin
                e_in1  = m_rf[pend[9:7]];
                e_in2  = m_rf[pend[6:4]];
                e_mode = pend[15:13];
                phase  = 1;
            end else if (phase == 1) begin
                e_result = alu_fn(e_in1, e_in2, e_mode);
                phase    = 2;
            end else begin
                retire_now = 1'b1;
                e_count    = e_count + 16'd1;
                phase      = -1;
            end
            if (ld_en && ld_addr != 3'd0) m_rf[ld_addr] = ld_data;
            if (retire_now && pend[12:10] != 3'd0) m_rf[pend[12:10]] = e_result;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("ready",    {15'd0, instr_ready}, {15'd0, phase == -1});
            chk("done",     {15'd0, done},        {15'd0, phase == 2});
            chk("alu_in1",  alu_in1,  e_in1);
            chk("alu_in2",  alu_in2,  e_in2);
            chk("alu_mode", {13'd0, alu_mode}, {13'd0, e_mode});
            chk("result",   result,   e_result);
            chk("op_count", op_count, e_count);
            chk("dbg_data", dbg_data, m_rf[dbg_addr]);
            if (done) done_cyc.push_back(cyc);
        end
    end

    // Stimulus changes 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic ld(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins);
        instr = ins; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        repeat (3) step();
    endtask

    // Same as issue, with a loader write landing on the write-back edge.
    task automatic issue_ld(input logic [15:0] ins, input logic [2:0] a, input logic [15:0] d);
        instr = ins; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        repeat (2) step();
        ld(a, d);
    endtask

    task automatic peek(input string name, input logic [2:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; instr = '0; instr_valid = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("reset ready",    {15'd0, instr_ready}, 16'd1);
        chk("reset op_count", op_count, 16'd0);
        chk("reset result",   result,   16'd0);

        // SUB r3,r1,r2 with 100-35, checked phase by phase
        ld(3'd1, 16'd100);
        ld(3'd2, 16'd35);
        dbg_addr = 3'd3;
        instr = 16'h2CA0; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        chk("exec mode", {13'd0, alu_mode}, 16'd1);
        chk("exec in1",  alu_in1, 16'd100);
        chk("exec in2",  alu_in2, 16'd35);
        chk("exec ready", {15'd0, instr_ready}, 16'd0);
        step();
        chk("wb done",   {15'd0, done}, 16'd1);
        chk("sub result", result, 16'd65);
        step();
        chk("sub done low", {15'd0, done}, 16'd0);
        peek("sub r3", 3'd3, 16'd65);
        chk("sub count", op_count, 16'd1);

        // negative difference
        ld(3'd1, 16'd0);
        ld(3'd2, 16'd32766);
        issue(16'h2CA0);
        chk("neg result", result, 16'h8002);
        peek("neg r3", 3'd3, 16'h8002);

        // write to r0 via write-back and via loader
        issue(16'h00A0);
        chk("r0 result", result, 16'h7FFE);
        peek("r0 wb", 3'd0, 16'd0);
        chk("r0 count", op_count, 16'd3);
        ld(3'd0, 16'hFFFF);
        peek("r0 ld", 3'd0, 16'd0);

        // back-to-back: XOR r5,r3,r2 then OR r6,r5,r3 with valid held high
        done_cyc.delete();
        instr = 16'hF5A0; instr_valid = 1'b1;
        step();
        instr = 16'hBAB0;
        repeat (4) step();
        instr_valid = 1'b0;
        repeat (4) step();
        chk("b2b done pulses", 16'(done_cyc.size()), 16'd2);
        if (done_cyc.size() == 2)
            chk("b2b done spacing", 16'(done_cyc[1] - done_cyc[0]), 16'd4);
        peek("b2b r5", 3'd5, 16'hFFFC);
        peek("b2b r6", 3'd6, 16'hFFFE);
        chk("b2b count", op_count, 16'd5);

        // loader vs write-back collisions
        ld(3'd1, 16'd100);
        ld(3'd2, 16'd35);
        issue_ld(16'h2CA0, 3'd3, 16'h1234);
        peek("collide same r3", 3'd3, 16'd65);
        issue_ld(16'h2CA0, 3'd4, 16'h1234);
        peek("collide diff r3", 3'd3, 16'd65);
        peek("collide diff r4", 3'd4, 16'h1234);

        // all ALU modes into r7 from r1=100, r2=35
        for (int m = 0; m < 8; m++) issue({3'(m), 3'd7, 3'd1, 3'd2, 4'd0});
        chk("xor result", result, 16'd71);
        peek("xor r7", 3'd7, 16'd71);

        // reset asserted during EXEC discards the instruction
        done_cyc.delete();
        instr = 16'h2CA0; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst ready",    {15'd0, instr_ready}, 16'd1);
        chk("rst done",     {15'd0, done}, 16'd0);
        chk("rst op_count", op_count, 16'd0);
        chk("rst result",   result,   16'd0);
        chk("rst alu_in1",  alu_in1,  16'd0);
        peek("rst r3", 3'd3, 16'd0);
        peek("rst r1", 3'd1, 16'd0);
        repeat (3) step();
        chk("rst no done", 16'(done_cyc.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
